// File: rtl/seq_divider_pkg.sv
// Shared widths and FSM state type for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DIVIDEND_W = 8;
  localparam int unsigned DIVISOR_W  = 4;
  localparam int unsigned ITER_N     = 8;
  localparam int unsigned REM_W      = DIVISOR_W + 1;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [REM_W-1:0]     rem_i,
  input  logic [DIVISOR_W-1:0] div_i,
  input  logic                 bit_i,
  output logic [REM_W-1:0]     rem_o,
  output logic                 qbit_o
);

  logic [REM_W:0]   shifted;
  logic [REM_W-1:0] diff;

  // rem_i[4] is only ever set when dividing by zero, where every trial subtraction succeeds.
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {2'b00, div_i});
    diff    = shifted[REM_W-1:0] - {1'b0, div_i};
    rem_o   = qbit_o ? diff : shifted[REM_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// 8-bit by 4-bit sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_DZ_FAST_EN to finish divide-by-zero at the capture edge instead of iterating.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [3:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       dz
);

  state_e                 state_q, state_d;
  logic [DIVIDEND_W-1:0]  quo_q, quo_d;
  logic [DIVISOR_W-1:0]   div_q, div_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dz_q, dz_d;
  logic [REM_W-1:0]       step_rem;
  logic                   step_qbit;

  // quo_q starts as the dividend and fills with quotient bits as dividend bits shift out the top.
  div_step u_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .bit_i  (quo_q[DIVIDEND_W-1]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          quo_d   = x;
          div_d   = y;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (y == '0);
          state_d = StCalc;
`ifdef SEQ_DIVIDER_DZ_FAST_EN
          if (y == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, x[DIVISOR_W-1:0]};
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        quo_d = {quo_q[DIVIDEND_W-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(ITER_N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign q         = quo_q;
  assign r         = rem_q[DIVISOR_W-1:0];
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider against an arithmetic reference (x / y, x % y, divide-by-zero rule).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0;
  logic [3:0] y = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;

  int errors = 0;
  int checks = 0;

  bit         exp_live = 1'b0;
  logic [7:0] exp_q = '0;
  logic [3:0] exp_r = '0;
  logic       exp_dz = 1'b0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] mq, output logic [3:0] mr, output logic mdz);
    if (b == 4'd0) begin
      mq  = 8'hFF;
      mr  = a[3:0];
      mdz = 1'b1;
    end else begin
      mq  = a / {4'd0, b};
      mr  = 4'(a % {4'd0, b});
      mdz = 1'b0;
    end
  endfunction

  // Result checker: whenever a result is offered it must match the pending reference.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!exp_live) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("q", {24'd0, q}, {24'd0, exp_q});
        check("r", {28'd0, r}, {28'd0, exp_r});
        check("dz", {31'd0, dz}, {31'd0, exp_dz});
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_live = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // stall_n < 0: random out_ready; otherwise hold out_ready low for stall_n cycles of out_valid.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int stall_n);
    int n, lat, exp_lat, waited;
    bit done;
    logic [7:0] mq;
    logic [3:0] mr;
    logic mdz;
    model(a, b, mq, mr, mdz);
    exp_lat = 9;
`ifdef SEQ_DIVIDER_DZ_FAST_EN
    if (b == 4'd0) exp_lat = 1;
`endif
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    exp_q    = mq;
    exp_r    = mr;
    exp_dz   = mdz;
    exp_live = 1'b1;
    n   = 0;
    lat = 0;
    while (lat == 0 && n < 20) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      x         = 8'($urandom);
      y         = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        lat = n + 1;
      end else begin
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        n++;
      end
    end
    check("latency", lat, exp_lat);
    if (lat == 0) begin
      do_reset();
      return;
    end
    waited = 0;
    done   = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (stall_n >= 0) out_ready = (waited >= stall_n);
      else              out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      x        = 8'($urandom);
      y        = 4'($urandom);
      @(posedge clk);
      #1;
      if (out_ready) begin
        exp_live = 1'b0;
        done     = 1'b1;
      end else begin
        waited++;
        @(negedge clk);
        check("out_valid_hold", {31'd0, out_valid}, 32'd1);
      end
    end
    check("handshake_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("no_accept_on_handshake", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] mq;
    logic [3:0] mr;
    logic mdz;
    int cyc;

    // Pin the reference against hand-computed results.
    model(8'd200, 4'd7, mq, mr, mdz);
    check("model_200_7_q", {24'd0, mq}, 32'd28);
    check("model_200_7_r", {28'd0, mr}, 32'd4);
    model(8'd255, 4'd15, mq, mr, mdz);
    check("model_255_15_q", {24'd0, mq}, 32'd17);
    model(8'd5, 4'd9, mq, mr, mdz);
    check("model_5_9_r", {28'd0, mr}, 32'd5);
    model(8'h2B, 4'd0, mq, mr, mdz);
    check("model_dz_q", {24'd0, mq}, 32'hFF);
    check("model_dz_r", {28'd0, mr}, 32'hB);
    check("model_dz_flag", {31'd0, mdz}, 32'd1);
    model(8'd100, 4'd3, mq, mr, mdz);
    check("model_100_3_q", {24'd0, mq}, 32'd33);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_q", {24'd0, q}, 32'd0);
    check("reset_r", {28'd0, r}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;

    do_op(8'd200, 4'd7, 0);
    do_op(8'd255, 4'd15, -1);
    do_op(8'd5, 4'd9, -1);
    do_op(8'h2B, 4'd0, -1);
    do_op(8'd100, 4'd3, 20);

    // Reset at E4 of 77 / 5, with in_valid and out_ready also high on that edge.
    @(negedge clk);
    in_valid = 1'b1;
    x = 8'd77;
    y = 4'd5;
    @(posedge clk);
    #1;
    exp_q = 8'd15;
    exp_r = 4'd2;
    exp_dz = 1'b0;
    exp_live = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_live = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rst_calc_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_calc_q", {24'd0, q}, 32'd0);
    check("rst_calc_r", {28'd0, r}, 32'd0);
    check("rst_calc_dz", {31'd0, dz}, 32'd0);
    check("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(posedge clk);
    do_op(8'd77, 4'd5, -1);

    // Reset while a result waits in DONE.
    @(negedge clk);
    in_valid = 1'b1;
    x = 8'd9;
    y = 4'd2;
    @(posedge clk);
    #1;
    exp_q = 8'd4;
    exp_r = 4'd1;
    exp_dz = 1'b0;
    exp_live = 1'b1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_live = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done_q", {24'd0, q}, 32'd0);
    repeat (12) @(posedge clk);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(8'(a), 4'(b), -1);
      end
    end
    for (int i = 0; i < 100; i++) begin
      do_op(8'($urandom), 4'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  x/y operands valid.
REQ-004 in_ready  output  1  block accepts an operand pair this cycle.
REQ-005 x  input  8  unsigned dividend.
REQ-006 y  input  4  unsigned divisor.
REQ-007 out_valid  output  1  q/r/dz hold a valid result.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 q  output  8  unsigned quotient.
REQ-010 r  output  4  unsigned remainder.
REQ-011 dz  output  1  result came from a divide-by-zero.

Function
REQ-012 Inverse operation to the team's 4x4 array multiplier: for y!=0, x == q*y + r with r < y, exact over all 4096 operand pairs.
REQ-013 Algorithm: radix-2 restoring division, one quotient bit per cycle, MSB first; 5-bit partial remainder; 4-bit iteration counter.
REQ-014 FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE: in_valid=1 captures x, y; clears partial remainder and counter; goes to CALC (capture edge = E0).
REQ-016 CALC: each edge shifts the next dividend bit into the partial remainder; if partial remainder >= {1'b0,y}, subtract and set the quotient bit, else set it to 0.
REQ-017 CALC runs exactly 8 iterations (E1..E8); at E8 goes to DONE; out_valid first sampled high at E9 (latency 9).
REQ-018 DONE: out_valid=1; q, r, dz held stable until out_valid&out_ready; on that edge goes to IDLE and out_valid drops.
REQ-019 No accept on the result-handshake edge; next operand accepted no earlier than the following edge.
REQ-020 y==0: q=8'hFF, r=x[3:0], dz=1 (the natural restoring result; both config variants give it).
REQ-021 in_valid while not in IDLE is ignored; x/y changes after E0 do not affect the result.
REQ-022 Back-pressure of any length preserves the result unchanged.

Reset
REQ-023 rst forces IDLE and out_valid=0, q=0, r=0, dz=0, counter=0 on the same edge, from any state.
REQ-024 rst mid-CALC or in DONE discards the operation; no partial result appears afterwards.
REQ-025 rst has priority over in_valid and out_ready on the same edge.

Configuration
REQ-026 Macro SEQ_DIVIDER_DZ_FAST_EN.
REQ-027 Defined: y==0 at capture goes IDLE->DONE at E0 with REQ-020 values; out_valid sampled high at E1 (latency 1).
REQ-028 Undefined: y==0 runs the full 8 CALC iterations; same values, latency 9.
REQ-029 Both variants: identical ports and identical y!=0 behaviour.

Structure
REQ-030 Shared package seq_divider_pkg: DIVIDEND_W=8, DIVISOR_W=4, ITER_N=8, FSM state enum type.
REQ-031 One combinational sub-module div_step: one restoring step (partial remainder, divisor, incoming bit -> next remainder, quotient bit); instantiated once and reused each cycle.

Verification
REQ-032 x=200, y=7 -> q=28, r=4, dz=0; out_valid at E9.
REQ-033 x=255, y=15 -> q=17, r=0; then x=5, y=9 -> q=0, r=5.
REQ-034 x=0x2B, y=0 -> q=0xFF, r=0xB, dz=1; out_valid at E1 with the macro, E9 without.
REQ-035 x=100, y=3 with out_ready=0 for 20 cycles after DONE -> q=33, r=1 held; in_ready=0 throughout; in_valid pulses ignored.
REQ-036 rst at E4 of x=77, y=5 -> IDLE, all outputs 0 next cycle; then x=77, y=5 -> q=15, r=2.
REQ-037 Exhaustive sweep of all 4096 x/y pairs, random out_ready -> every result matches the REQ-012/REQ-020 reference.
